// File: rtl/register_file_param.sv
// -----------------------------------------------------------------------------
// register_file_param
//
// Parameterised register file with one write port and two combinational read
// ports. Every register has a valid bit that is set by a write and cleared by
// reset. Optional same-cycle write-to-read forwarding (BYPASS) and an optional
// hard-wired zero register at address 0 (ZERO_REG).
//
// Parameters
//   DATA_W     register width in bits (1..64)
//   ADDR_W     address width; the file holds 2**ADDR_W registers
//   ZERO_REG   1: address 0 reads constant 0 with valid=1, writes to it are dropped
//   BYPASS     1: a write in progress is forwarded to read ports addressing it
//   RESET_VAL  value loaded into every register by reset
//
// Ports
//   clk          clock, all state updates on the rising edge
//   clr          synchronous active-high reset
//   Write_En     write strobe
//   Write_Addr   register index written
//   Write_Data   value written
//   Read_Addr_A  read index, port A
//   Read_Addr_B  read index, port B
//   OutA, OutB   read data (zero-cycle latency)
//   ValidA/B     addressed register has been written since the last reset
// -----------------------------------------------------------------------------
module register_file_param #(
    parameter int                DATA_W    = 16,
    parameter int                ADDR_W    = 3,
    parameter bit                ZERO_REG  = 1'b0,
    parameter bit                BYPASS    = 1'b1,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              Write_En,
    input  logic [ADDR_W-1:0] Write_Addr,
    input  logic [DATA_W-1:0] Write_Data,
    input  logic [ADDR_W-1:0] Read_Addr_A,
    input  logic [ADDR_W-1:0] Read_Addr_B,
    output logic [DATA_W-1:0] OutA,
    output logic [DATA_W-1:0] OutB,
    output logic              ValidA,
    output logic              ValidB
);

    localparam int DEPTH = 1 << ADDR_W;

    // Every register must be reset to RESET_VAL in one edge, so storage is
    // built from flops rather than a RAM macro.
    logic [DATA_W-1:0] r_mem   [DEPTH];
    logic              r_valid [DEPTH];

    genvar gi;

    // -------------------------------------------------------------------------
    // Storage: one register plus valid bit per address
    // -------------------------------------------------------------------------
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_reg
            if (ZERO_REG && (gi == 0)) begin : g_zero
                // Address 0 is never written; its read value is forced in the
                // read mux, so this register just sits at RESET_VAL.
                always_ff @(posedge clk) begin
                    r_mem[gi]   <= RESET_VAL;
                    r_valid[gi] <= 1'b0;
                end
            end else begin : g_store
                logic w_wr_sel;
                assign w_wr_sel = Write_En && (Write_Addr == ADDR_W'(gi));

                // clr has priority, so a write coincident with reset is lost.
                always_ff @(posedge clk) begin
                    if (clr) begin
                        r_mem[gi]   <= RESET_VAL;
                        r_valid[gi] <= 1'b0;
                    end else if (w_wr_sel) begin
                        r_mem[gi]   <= Write_Data;
                        r_valid[gi] <= 1'b1;
                    end
                end
            end
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Read ports: gi=0 is port A, gi=1 is port B
    // -------------------------------------------------------------------------
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            logic [ADDR_W-1:0] w_raddr;
            logic              w_bypass;
            logic [DATA_W-1:0] w_data;
            logic              w_vld;

            assign w_raddr = (gi == 0) ? Read_Addr_A : Read_Addr_B;

            // Forwarding is disabled during reset so a write that reset is
            // about to discard never becomes visible.
            assign w_bypass = BYPASS && !clr && Write_En && (w_raddr == Write_Addr);

            always_comb begin
                w_data = r_mem[w_raddr];
                w_vld  = r_valid[w_raddr];
                if (w_bypass) begin
                    w_data = Write_Data;
                    w_vld  = 1'b1;
                end
                // Zero register overrides forwarding as well as storage.
                if (ZERO_REG && (w_raddr == '0)) begin
                    w_data = '0;
                    w_vld  = 1'b1;
                end
            end
        end
    endgenerate

    assign OutA   = g_port[0].w_data;
    assign ValidA = g_port[0].w_vld;
    assign OutB   = g_port[1].w_data;
    assign ValidB = g_port[1].w_vld;

endmodule

// File: tb/tb_register_file_param.sv
// -----------------------------------------------------------------------------
// tb_register_file_param
//
// Directed bench for register_file_param. Four instances share one clock and
// reset:
//   u_def  : defaults (16-bit, 8 regs, BYPASS=1, ZERO_REG=0, RESET_VAL=0)
//   u_nbyp : BYPASS=0
//   u_zero : ZERO_REG=1
//   u_wide : DATA_W=32, ADDR_W=4, RESET_VAL=0xDEADBEEF
// The three 16-bit instances receive identical write/read stimulus.
// Inputs change just after the falling edge; outputs are sampled 1 time unit
// later, well away from the rising edge.
// -----------------------------------------------------------------------------
module tb_register_file_param;

    logic        clk;
    logic        clr;
    logic        we;
    logic [2:0]  waddr;
    logic [15:0] wdata;
    logic [2:0]  ra;
    logic [2:0]  rb;

    logic [15:0] oa_def,  ob_def,  oa_nbyp, ob_nbyp, oa_zero, ob_zero;
    logic        va_def,  vb_def,  va_nbyp, vb_nbyp, va_zero, vb_zero;

    logic        we_w;
    logic [3:0]  waddr_w;
    logic [31:0] wdata_w;
    logic [3:0]  ra_w;
    logic [3:0]  rb_w;
    logic [31:0] oa_wide, ob_wide;
    logic        va_wide, vb_wide;

    int n_vec;
    int n_err;

    logic [15:0] fill_val [8];

    register_file_param u_def (
        .clk(clk), .clr(clr), .Write_En(we), .Write_Addr(waddr), .Write_Data(wdata),
        .Read_Addr_A(ra), .Read_Addr_B(rb),
        .OutA(oa_def), .OutB(ob_def), .ValidA(va_def), .ValidB(vb_def)
    );

    register_file_param #(.BYPASS(1'b0)) u_nbyp (
        .clk(clk), .clr(clr), .Write_En(we), .Write_Addr(waddr), .Write_Data(wdata),
        .Read_Addr_A(ra), .Read_Addr_B(rb),
        .OutA(oa_nbyp), .OutB(ob_nbyp), .ValidA(va_nbyp), .ValidB(vb_nbyp)
    );

    register_file_param #(.ZERO_REG(1'b1)) u_zero (
        .clk(clk), .clr(clr), .Write_En(we), .Write_Addr(waddr), .Write_Data(wdata),
        .Read_Addr_A(ra), .Read_Addr_B(rb),
        .OutA(oa_zero), .OutB(ob_zero), .ValidA(va_zero), .ValidB(vb_zero)
    );

    register_file_param #(.DATA_W(32), .ADDR_W(4), .RESET_VAL(32'hDEADBEEF)) u_wide (
        .clk(clk), .clr(clr), .Write_En(we_w), .Write_Addr(waddr_w), .Write_Data(wdata_w),
        .Read_Addr_A(ra_w), .Read_Addr_B(rb_w),
        .OutA(oa_wide), .OutB(ob_wide), .ValidA(va_wide), .ValidB(vb_wide)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s : got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end else begin
            $display("ok   %s : 0x%0h", tag, got);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        fill_val[0] = 16'h0012; fill_val[1] = 16'h0034;
        fill_val[2] = 16'h0056; fill_val[3] = 16'h0078;
        fill_val[4] = 16'h009A; fill_val[5] = 16'h00BC;
        fill_val[6] = 16'h00DE; fill_val[7] = 16'h00F0;

        clr = 1'b1; we = 1'b0; waddr = '0; wdata = '0; ra = '0; rb = '0;
        we_w = 1'b0; waddr_w = '0; wdata_w = '0; ra_w = '0; rb_w = '0;

        // ---- reset held 15 cycles -------------------------------------------
        repeat (15) @(negedge clk);
        ra = 3'd3; rb = 3'd0;
        #1;
        check("rst_def_outA",   64'(oa_def),  64'h0);
        check("rst_def_validA", 64'(va_def),  64'h0);
        check("rst_zero_outB0", 64'(ob_zero), 64'h0);
        check("rst_zero_valB0", 64'(vb_zero), 64'h1);
        check("rst_def_valB0",  64'(vb_def),  64'h0);

        // write during reset: no forwarding, and no effect after the edge
        we = 1'b1; waddr = 3'd3; wdata = 16'h1234;
        #1;
        check("clr_nobyp_outA",   64'(oa_def), 64'h0);
        check("clr_nobyp_validA", 64'(va_def), 64'h0);
        @(negedge clk);
        clr = 1'b0; we = 1'b0;
        #1;
        check("clr_wr_lost_outA",   64'(oa_def), 64'h0);
        check("clr_wr_lost_validA", 64'(va_def), 64'h0);

        // ---- bypass: write 0xAAAA to address 5 ------------------------------
        @(negedge clk);
        we = 1'b1; waddr = 3'd5; wdata = 16'hAAAA; ra = 3'd5; rb = 3'd5;
        #1;
        check("byp_def_outA",    64'(oa_def),  64'hAAAA);
        check("byp_def_outB",    64'(ob_def),  64'hAAAA);
        check("byp_def_validA",  64'(va_def),  64'h1);
        check("byp_def_validB",  64'(vb_def),  64'h1);
        check("nbyp_old_outA",   64'(oa_nbyp), 64'h0);
        check("nbyp_old_validA", 64'(va_nbyp), 64'h0);
        @(negedge clk);
        we = 1'b0; wdata = 16'h1111;
        #1;
        check("nbyp_new_outA",   64'(oa_nbyp), 64'hAAAA);
        check("nbyp_new_validA", 64'(va_nbyp), 64'h1);
        check("nbyp_new_outB",   64'(ob_nbyp), 64'hAAAA);
        @(negedge clk);
        #1;
        check("we0_hold_def",  64'(oa_def),  64'hAAAA);
        check("we0_hold_nbyp", 64'(oa_nbyp), 64'hAAAA);

        // ---- valid tracking: reset, write only address 3 --------------------
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0; we = 1'b1; waddr = 3'd3; wdata = 16'h0333;
        @(negedge clk);
        we = 1'b0;
        for (int i = 0; i < 8; i++) begin
            ra = 3'(i); rb = 3'(i);
            #1;
            check($sformatf("vtrk_def_outA[%0d]", i),   64'(oa_def), (i == 3) ? 64'h0333 : 64'h0);
            check($sformatf("vtrk_def_validA[%0d]", i), 64'(va_def), (i == 3) ? 64'h1 : 64'h0);
            check($sformatf("vtrk_zero_validB[%0d]", i), 64'(vb_zero), (i == 3 || i == 0) ? 64'h1 : 64'h0);
            @(negedge clk);
        end

        // ---- fill 0..7, forwarding visible on the write cycle ---------------
        for (int i = 0; i < 8; i++) begin
            we = 1'b1; waddr = 3'(i); wdata = fill_val[i]; ra = 3'(i); rb = 3'(i);
            #1;
            check($sformatf("fill_byp_outA[%0d]", i), 64'(oa_def), 64'(fill_val[i]));
            check($sformatf("fill_zero_outA[%0d]", i), 64'(oa_zero), (i == 0) ? 64'h0 : 64'(fill_val[i]));
            @(negedge clk);
        end
        we = 1'b0;
        for (int i = 0; i < 8; i++) begin
            ra = 3'(i); rb = 3'(7 - i);
            #1;
            check($sformatf("sweep_def_outA[%0d]", i),   64'(oa_def),  64'(fill_val[i]));
            check($sformatf("sweep_def_validA[%0d]", i), 64'(va_def),  64'h1);
            check($sformatf("sweep_def_outB[%0d]", 7 - i), 64'(ob_def), 64'(fill_val[7 - i]));
            check($sformatf("sweep_def_validB[%0d]", 7 - i), 64'(vb_def), 64'h1);
            check($sformatf("sweep_nbyp_outA[%0d]", i),  64'(oa_nbyp), 64'(fill_val[i]));
            check($sformatf("sweep_zero_outA[%0d]", i),  64'(oa_zero), (i == 0) ? 64'h0 : 64'(fill_val[i]));
            @(negedge clk);
        end

        // ---- zero register: write 0x1234 to address 0 -----------------------
        we = 1'b1; waddr = 3'd0; wdata = 16'h1234; ra = 3'd0; rb = 3'd1;
        #1;
        check("zr_byp_outA",   64'(oa_zero), 64'h0);
        check("zr_byp_validA", 64'(va_zero), 64'h1);
        check("zr_def_bypA",   64'(oa_def),  64'h1234);
        @(negedge clk);
        we = 1'b0;
        #1;
        check("zr_outA0",   64'(oa_zero), 64'h0);
        check("zr_validA0", 64'(va_zero), 64'h1);
        check("zr_outB1",   64'(ob_zero), 64'h0034);
        check("zr_def_outA0", 64'(oa_def), 64'h1234);
        check("zr_nbyp_outA0", 64'(oa_nbyp), 64'h1234);

        // ---- reset mid-operation with a coincident write --------------------
        @(negedge clk);
        clr = 1'b1; we = 1'b1; waddr = 3'd2; wdata = 16'h5555; ra = 3'd2; rb = 3'd2;
        #1;
        check("midclr_def_outA",   64'(oa_def),  64'h0056);
        check("midclr_def_outB",   64'(ob_def),  64'h0056);
        check("midclr_nbyp_outA",  64'(oa_nbyp), 64'h0056);
        @(negedge clk);
        clr = 1'b0; we = 1'b0;
        for (int i = 0; i < 8; i++) begin
            ra = 3'(i); rb = 3'(i);
            #1;
            check($sformatf("postclr_def_outA[%0d]", i),   64'(oa_def),  64'h0);
            check($sformatf("postclr_def_validA[%0d]", i), 64'(va_def),  64'h0);
            check($sformatf("postclr_zero_validB[%0d]", i), 64'(vb_zero), (i == 0) ? 64'h1 : 64'h0);
            @(negedge clk);
        end

        // ---- wide instance: 16 x 32-bit, RESET_VAL=0xDEADBEEF ---------------
        for (int i = 0; i < 16; i++) begin
            ra_w = 4'(i); rb_w = 4'(15 - i);
            #1;
            check($sformatf("wide_rst_outA[%0d]", i),   64'(oa_wide), 64'hDEADBEEF);
            check($sformatf("wide_rst_validA[%0d]", i), 64'(va_wide), 64'h0);
            @(negedge clk);
        end
        we_w = 1'b1; waddr_w = 4'd15; wdata_w = 32'hFFFFFFFF;
        @(negedge clk);
        we_w = 1'b0; ra_w = 4'd15; rb_w = 4'd14;
        #1;
        check("wide_wr_outA15",   64'(oa_wide), 64'hFFFFFFFF);
        check("wide_wr_validA15", 64'(va_wide), 64'h1);
        check("wide_outB14",      64'(ob_wide), 64'hDEADBEEF);
        check("wide_validB14",    64'(vb_wide), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
